// File: rtl/display_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | display_pkg : shared constants and helpers for display scan logic  |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package display_pkg;

  // All segments off for a common-anode 8-segment digit.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // 100 MHz board clock: 1 ms per digit, blink half-period of 64 frames.
  localparam int DEFAULT_DIVIDE       = 100000;
  localparam int DEFAULT_BLINK_FRAMES = 64;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | scan_prescaler : free-running divider, tick on the last count      |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
module scan_prescaler
  import display_pkg::*;
#(
  parameter int DIVIDE = DEFAULT_DIVIDE
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int            CW   = idx_width(DIVIDE);
  localparam logic [CW-1:0] LAST = CW'(DIVIDE - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q + CW'(1);
    if (count_q == LAST) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == LAST);

endmodule
`default_nettype wire

// File: rtl/digit_scan_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | digit_scan_mux : frame-snapshotted multiplexed digit driver with   |
// |                  per-channel blanking and blinking                 |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
module digit_scan_mux
  import display_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               CHANNELS     = 4,
  parameter int               DIVIDE       = DEFAULT_DIVIDE,
  parameter int               BLINK_FRAMES = DEFAULT_BLINK_FRAMES,
  parameter logic [WIDTH-1:0] BLANK        = {WIDTH{1'b1}}
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [CHANNELS*WIDTH-1:0]        data_in,
  input  logic [CHANNELS-1:0]              en_mask,
  input  logic [CHANNELS-1:0]              blink_mask,
  output logic [WIDTH-1:0]                 y,
  output logic [CHANNELS-1:0]              sel_n,
  output logic [idx_width(CHANNELS)-1:0]   idx,
  output logic                             frame_start
);

  localparam int            IW       = idx_width(CHANNELS);
  localparam logic [IW-1:0] LAST_IDX = IW'(CHANNELS - 1);
  localparam int            FW       = idx_width(BLINK_FRAMES + 1);
  localparam logic [FW-1:0] FRAMES_N = FW'(BLINK_FRAMES);

  logic                      tick;
  logic                      wrap;

  logic [IW-1:0]             idx_q, idx_d;
  logic [CHANNELS*WIDTH-1:0] snap_data_q, snap_data_d;
  logic [CHANNELS-1:0]       snap_en_q, snap_en_d;
  logic [CHANNELS-1:0]       snap_blink_q, snap_blink_d;
  logic [FW-1:0]             frame_cnt_q, frame_cnt_d;
  logic                      phase_q, phase_d;

  logic                      visible_d;
  logic [WIDTH-1:0]          y_q, y_d;
  logic [CHANNELS-1:0]       sel_n_q, sel_n_d;
  logic                      fs_q, fs_d;

  scan_prescaler #(
    .DIVIDE (DIVIDE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign wrap = tick && (idx_q == LAST_IDX);

  always_comb begin
    idx_d        = idx_q;
    snap_data_d  = snap_data_q;
    snap_en_d    = snap_en_q;
    snap_blink_d = snap_blink_q;
    frame_cnt_d  = frame_cnt_q;
    phase_d      = phase_q;

    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end

    // frame_cnt_q counts frames already shown in the current blink
    // half-period; a full half-period flips the phase for the new frame.
    if (wrap) begin
      snap_data_d  = data_in;
      snap_en_d    = en_mask;
      snap_blink_d = blink_mask;
      if (frame_cnt_q == FRAMES_N) begin
        frame_cnt_d = FW'(1);
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end

    visible_d = snap_en_d[idx_d] && !(snap_blink_d[idx_d] && phase_d);
    y_d       = visible_d ? snap_data_d[idx_d*WIDTH +: WIDTH] : BLANK;
    fs_d      = wrap;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_sel
    assign sel_n_d[i] = !(visible_d && (idx_d == IW'(i)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q        <= LAST_IDX;
      snap_data_q  <= '0;
      snap_en_q    <= '0;
      snap_blink_q <= '0;
      frame_cnt_q  <= '0;
      phase_q      <= 1'b0;
      y_q          <= BLANK;
      sel_n_q      <= '1;
      fs_q         <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      snap_data_q  <= snap_data_d;
      snap_en_q    <= snap_en_d;
      snap_blink_q <= snap_blink_d;
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
      y_q          <= y_d;
      sel_n_q      <= sel_n_d;
      fs_q         <= fs_d;
    end
  end

  assign y           = y_q;
  assign sel_n       = sel_n_q;
  assign idx         = idx_q;
  assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_digit_scan_mux : scoreboard bench for digit_scan_mux            |
// | Revision          : 1.0                                            |
// +--------------------------------------------------------------------+
module tb_digit_scan_mux;

  localparam int W  = 8;
  localparam int C  = 4;
  localparam int D  = 4;
  localparam int BF = 2;
  localparam int C3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n = 1'b0;
  logic [C*W-1:0]   data_in = '0;
  logic [C-1:0]     en_mask = '0;
  logic [C-1:0]     blink_mask = '0;
  logic [W-1:0]     y;
  logic [C-1:0]     sel_n;
  logic [1:0]       idx;
  logic             frame_start;

  logic             rb_n = 1'b0;
  logic [C3*W-1:0]  data_b = 24'h332211;
  logic [C3-1:0]    en_b = 3'b111;
  logic [C3-1:0]    blink_b = 3'b000;
  logic [W-1:0]     y_b;
  logic [C3-1:0]    sel_b;
  logic [1:0]       idx_b;
  logic             fs_b;

  digit_scan_mux #(
    .WIDTH(W), .CHANNELS(C), .DIVIDE(D), .BLINK_FRAMES(BF), .BLANK(8'hFF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .en_mask(en_mask),
    .blink_mask(blink_mask), .y(y), .sel_n(sel_n), .idx(idx),
    .frame_start(frame_start)
  );

  digit_scan_mux #(
    .WIDTH(W), .CHANNELS(C3), .DIVIDE(1), .BLINK_FRAMES(BF), .BLANK(8'hFF)
  ) dut3 (
    .clk(clk), .reset_n(rb_n), .data_in(data_b), .en_mask(en_b),
    .blink_mask(blink_b), .y(y_b), .sel_n(sel_b), .idx(idx_b),
    .frame_start(fs_b)
  );

  typedef struct packed {
    logic [W-1:0] y;
    logic [C-1:0] sel_n;
    logic [1:0]   idx;
    logic         fs;
  } exp_t;

  typedef struct packed {
    logic [W-1:0]  y;
    logic [C3-1:0] sel_n;
    logic [1:0]    idx;
    logic          fs;
  } exp3_t;

  exp_t  q_a[$];
  exp3_t q_b[$];
  int checks = 0;
  int errors = 0;

  // Reference for the 4-channel instance: derived from the number of
  // clock edges since reset release (tick every D edges, frame every C ticks).
  int             m_n = 0;
  int             m_idx = C - 1;
  int             m_phase = 0;
  logic [C*W-1:0] m_data = '0;
  logic [C-1:0]   m_en = '0;
  logic [C-1:0]   m_blink = '0;
  exp_t           m_cur = '{y: 8'hFF, sel_n: 4'hF, idx: 2'd3, fs: 1'b0};

  always @(posedge clk or negedge reset_n) begin
    int k;
    logic [C-1:0] one;
    if (!reset_n) begin
      m_n   = 0;
      m_idx = C - 1;
      m_cur = '{y: 8'hFF, sel_n: 4'hF, idx: 2'd3, fs: 1'b0};
      q_a.delete();
    end else begin
      one = 1;
      m_n++;
      m_cur.fs = 1'b0;
      if (m_n % D == 0) begin
        k     = m_n / D;
        m_idx = (k - 1) % C;
        if (m_idx == 0) begin
          m_data   = data_in;
          m_en     = en_mask;
          m_blink  = blink_mask;
          m_phase  = (((k - 1) / C) / BF) % 2;
          m_cur.fs = 1'b1;
        end
        m_cur.idx = 2'(m_idx);
        if (m_en[m_idx] && !(m_blink[m_idx] && m_phase == 1)) begin
          m_cur.y     = m_data[m_idx*W +: W];
          m_cur.sel_n = ~(one << m_idx);
        end else begin
          m_cur.y     = 8'hFF;
          m_cur.sel_n = 4'hF;
        end
      end
      q_a.push_back(m_cur);
    end
  end

  always @(posedge clk) begin
    exp_t e;
    exp_t a;
    #1;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      a = {y, sel_n, idx, frame_start};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scan4 t=%0t got y=%h sel_n=%h idx=%0d fs=%b want y=%h sel_n=%h idx=%0d fs=%b",
                 $time, a.y, a.sel_n, a.idx, a.fs, e.y, e.sel_n, e.idx, e.fs);
      end
      checks++;
      if ($countones(~sel_n) > 1) begin
        errors++;
        $display("FAIL onehot4 t=%0t got sel_n=%b want at most one low bit", $time, sel_n);
      end
    end
  end

  // Reference for the 3-channel, DIVIDE=1 instance.
  int nb = 0;
  always @(posedge clk or negedge rb_n) begin
    exp3_t e;
    int    i;
    logic [C3-1:0] one3;
    if (!rb_n) begin
      nb = 0;
      q_b.delete();
    end else begin
      one3    = 1;
      nb++;
      i       = (nb - 1) % C3;
      e.idx   = 2'(i);
      e.fs    = (i == 0);
      e.y     = data_b[i*W +: W];
      e.sel_n = ~(one3 << i);
      q_b.push_back(e);
    end
  end

  always @(posedge clk) begin
    exp3_t e;
    exp3_t a;
    #1;
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      a = {y_b, sel_b, idx_b, fs_b};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scan3 t=%0t got y=%h sel_n=%b idx=%0d fs=%b want y=%h sel_n=%b idx=%0d fs=%b",
                 $time, a.y, a.sel_n, a.idx, a.fs, e.y, e.sel_n, e.idx, e.fs);
      end
      checks++;
      if (idx_b > 2'd2) begin
        errors++;
        $display("FAIL idx3_range t=%0t got idx=%0d want <= 2", $time, idx_b);
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({y, sel_n, idx, frame_start} !== {8'hFF, 4'hF, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL %s got y=%h sel_n=%h idx=%0d fs=%b want y=ff sel_n=f idx=3 fs=0",
               tag, y, sel_n, idx, frame_start);
    end
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      wait_neg($urandom_range(1, 20));
      case ($urandom_range(0, 2))
        0:       data_in    = $urandom;
        1:       en_mask    = 4'($urandom);
        default: blink_mask = 4'($urandom);
      endcase
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want $finish");
    $fatal(1);
  end

  initial begin
    int guard;
    int lat;

    data_in    = 32'h44_33_22_11;
    en_mask    = 4'hF;
    blink_mask = 4'h0;
    wait_neg(3);
    check_reset_vals("reset_initial");
    reset_n = 1'b1;
    rb_n    = 1'b1;

    // Mid-frame data change while channel 1 is shown, then a blanked channel.
    wait_neg(9);
    data_in = 32'hAA_BB_CC_DD;
    wait_neg(16);
    en_mask = 4'b1011;
    wait_neg(35);

    // Blink run from a fresh reset: channel 0 only.
    #1 reset_n = 1'b0;
    #1 check_reset_vals("reset_run2");
    wait_neg(2);
    data_in    = 32'h44_33_22_11;
    en_mask    = 4'hF;
    blink_mask = 4'b0001;
    reset_n    = 1'b1;
    wait_neg(100);

    random_phase(60);

    // Asynchronous reset in the middle of channel 2's dwell.
    guard = 0;
    while (!(m_idx == 2 && m_n % D == 1) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 400) begin
      errors++;
      $display("FAIL find_ch2 got no channel-2 dwell want one within 400 cycles");
    end
    #2 reset_n = 1'b0;
    #1 check_reset_vals("reset_async");
    wait_neg(3);
    check_reset_vals("reset_held");
    data_in    = 32'h44_33_22_11;
    en_mask    = 4'hF;
    blink_mask = 4'h0;
    reset_n    = 1'b1;
    for (lat = 1; lat <= 12; lat++) begin
      @(posedge clk);
      #1;
      if (frame_start === 1'b1) break;
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL restart_latency got %0d cycles want 4", lat);
    end

    random_phase(30);
    wait_neg(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
